// File: rtl/mont_preprocess.sv
// Montgomery-domain entry conversion: o_result = (i_a * 2^W) mod i_n, one modular doubling per cycle.
// Optional abort input enabled by defining MONT_PREPROCESS_ABORT_EN.
module mont_preprocess #(
    parameter int unsigned W = 256
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
`ifdef MONT_PREPROCESS_ABORT_EN
    input  logic         i_abort,
`endif
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_n,
    output logic [W-1:0] o_result,
    output logic         o_finished,
    output logic         o_busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [W:0]    t;
    logic [W:0]    t_nx;
    logic [W:0]    d;
    logic [W:0]    n_ext;
    logic [W:0]    t_step;
    logic [W-1:0]  n_r;
    logic [W-1:0]  n_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [W-1:0]  result_nx;
    logic          finished_nx;
    logic          busy_nx;
    logic          cnt_last;
    logic          abort;

`ifdef MONT_PREPROCESS_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    // One modular doubling: t stays below n_r, so d fits in W+1 bits.
    assign d        = {t[W-1:0], 1'b0};
    assign n_ext    = {1'b0, n_r};
    assign t_step   = (d >= n_ext) ? (d - n_ext) : d;
    assign cnt_last = (cnt == CW'(W - 1));

    // State register plus datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            t          <= '0;
            n_r        <= '0;
            cnt        <= '0;
            o_result   <= '0;
            o_finished <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_nx;
            t          <= t_nx;
            n_r        <= n_nx;
            cnt        <= cnt_nx;
            o_result   <= result_nx;
            o_finished <= finished_nx;
            o_busy     <= busy_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = RUN;
            RUN: begin
                if (abort)         state_nx = IDLE;
                else if (cnt_last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and registered-output next values; result lands with the finish pulse.
    always_comb begin
        t_nx        = t;
        n_nx        = n_r;
        cnt_nx      = cnt;
        result_nx   = o_result;
        finished_nx = 1'b0;
        busy_nx     = (state_nx != IDLE);
        case (state)
            IDLE: begin
                if (i_start) begin
                    t_nx   = {1'b0, i_a};
                    n_nx   = i_n;
                    cnt_nx = '0;
                end
            end
            RUN: begin
                t_nx   = t_step;
                cnt_nx = cnt + CW'(1);
                if (!abort && cnt_last) begin
                    result_nx   = t_step[W-1:0];
                    finished_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mont_preprocess.sv
// Directed and randomised self-checking bench for mont_preprocess (W = 256).
module tb_mont_preprocess;

    localparam int unsigned W = 256;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
`ifdef MONT_PREPROCESS_ABORT_EN
    logic         i_abort;
`endif
    logic [W-1:0] i_a;
    logic [W-1:0] i_n;
    logic [W-1:0] o_result;
    logic         o_finished;
    logic         o_busy;

    int n_cmp = 0;
    int n_err = 0;

    mont_preprocess #(.W(W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
`ifdef MONT_PREPROCESS_ABORT_EN
        .i_abort    (i_abort),
`endif
        .i_a        (i_a),
        .i_n        (i_n),
        .o_result   (o_result),
        .o_finished (o_finished),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int j = 0; j < W / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] n);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wn;
        wa = {a, {W{1'b0}}};
        wn = {{W{1'b0}}, n};
        return W'(wa % wn);
    endfunction

    // Montgomery product with b = 1: r * 2^-W mod n via right-shift reduction.
    function automatic logic [W-1:0] mont_mul_one(input logic [W-1:0] r, input logic [W-1:0] n);
        logic [W:0] t;
        t = {1'b0, r};
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + {1'b0, n};
            t = t >> 1;
        end
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        return t[W-1:0];
    endfunction

    // Called #1 after a rising edge; returns #1 after the first IDLE edge following the finish pulse.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] n, input bit noisy,
                          output logic [W-1:0] res);
        int  lat;
        bit  done;
        bit  busy_ok;
        i_a     = a;
        i_n     = n;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        lat     = 0;
        done    = 1'b0;
        busy_ok = 1'b1;
        while (!done && lat < 400) begin
            if (noisy) begin
                i_start = 1'b1;
                i_a     = rand_word();
                i_n     = rand_word();
            end
            if (!o_busy) busy_ok = 1'b0;
            @(posedge i_clk); #1;
            lat++;
            if (o_finished) done = 1'b1;
        end
        i_start = 1'b0;
        res     = o_result;
        check("finish_seen", W'(done), W'(1));
        check("latency", W'(lat), W'(W));
        check("busy_during_run", W'(busy_ok & o_busy), W'(1));
        @(posedge i_clk); #1;
        check("finish_single_pulse", W'(o_finished), W'(0));
        check("busy_after_done", W'(o_busy), W'(0));
    endtask

    logic [W-1:0] res;
    logic [W-1:0] ra;
    logic [W-1:0] rn;
    logic [W-1:0] all_ones;
    int           pulses;

    initial begin
        i_rst   = 1'b0;
        i_start = 1'b0;
        i_a     = '0;
        i_n     = '0;
`ifdef MONT_PREPROCESS_ABORT_EN
        i_abort = 1'b0;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_result", o_result, W'(0));
        check("reset_finished", W'(o_finished), W'(0));
        check("reset_busy", W'(o_busy), W'(0));
        i_rst = 1'b1;
        @(posedge i_clk); #1;

        // 2^256 mod 13 = 2^4 mod 13 = 3
        run_op(W'(1), W'(13), 1'b0, res);
        check("n13_a1", res, W'(3));
        // 5*3 mod 13 = 2, then back-to-back 3*2 mod 7 = 6
        run_op(W'(5), W'(13), 1'b0, res);
        check("n13_a5", res, W'(2));
        run_op(W'(3), W'(7), 1'b0, res);
        check("n7_a3", res, W'(6));

        all_ones = '1;
        run_op(W'(1), all_ones, 1'b0, res);
        check("nmax_a1", res, W'(1));
        run_op(W'(0), all_ones, 1'b0, res);
        check("nmax_a0", res, W'(0));

        for (int v = 0; v < 100; v++) begin
            rn = rand_word() | W'(1);
            if (rn == W'(1)) rn = W'(3);
            ra = rand_word() % rn;
            run_op(ra, rn, 1'b0, res);
            check("rand_result", res, ref_mod(ra, rn));
            check("rand_roundtrip", mont_mul_one(res, rn), ra);
        end

        // Start requests and operand changes during RUN must be ignored
        run_op(W'(5), W'(13), 1'b1, res);
        check("noisy_result", res, W'(2));

`ifdef MONT_PREPROCESS_ABORT_EN
        i_a = W'(1); i_n = W'(13); i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (50) @(posedge i_clk);
        #1;
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        check("abort_busy", W'(o_busy), W'(0));
        check("abort_finished", W'(o_finished), W'(0));
        check("abort_result_kept", o_result, W'(2));
        pulses = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge i_clk); #1;
            if (o_finished) pulses++;
        end
        check("abort_no_pulse", W'(pulses), W'(0));
        run_op(W'(3), W'(7), 1'b0, res);
        check("after_abort", res, W'(6));
`endif

        // Reset 100 cycles into RUN clears everything at once
        i_a = W'(1); i_n = W'(13); i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (100) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        check("midrst_result", o_result, W'(0));
        check("midrst_finished", W'(o_finished), W'(0));
        check("midrst_busy", W'(o_busy), W'(0));
        @(posedge i_clk); #1;
        i_rst  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge i_clk); #1;
            if (o_finished) pulses++;
        end
        check("midrst_no_pulse", W'(pulses), W'(0));
        run_op(W'(5), W'(13), 1'b0, res);
        check("after_reset", res, W'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
